// File: rtl/uart_arbiter_pkg.sv
// Shared types and constants for the UART TX arbiter: FSM states, the UART
// register map entry the arbiter writes to, and the byte-lane strobe.
package uart_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCKED = 2'd1,
      WRITE  = 2'd2
   } uart_arb_state_t;

   // Register map of the uart block; only the TX buffer entry is used here.
   typedef enum logic [1:0] {
      UART_CTRL      = 2'd0,
      UART_STATUS    = 2'd1,
      UART_RX_BUFFER = 2'd2,
      UART_TX_BUFFER = 2'd3
   } uart_registers_t;

   localparam logic [1:0] UART_TX_BUFFER_ADDR = UART_TX_BUFFER;
   localparam logic [3:0] UART_TX_STROBE      = 4'b0001;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart write port, as seen by the arbiter.
// master = arbiter side, slave = requesters/uart side.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid_i;
   logic [NUM_REQ*8-1:0] req_data_i;
   logic [NUM_REQ-1:0]   req_last_i;
   logic [NUM_REQ-1:0]   req_ready_o;
   logic [NUM_REQ-1:0]   grant_o;
   logic                 uart_write_o;
   logic [1:0]           uart_write_address_o;
   logic [31:0]          uart_write_data_o;
   logic [3:0]           uart_write_strobe_o;
   logic                 uart_write_error_i;
   logic                 uart_write_done_i;

   modport master (
      input  req_valid_i, req_data_i, req_last_i, uart_write_error_i, uart_write_done_i,
      output req_ready_o, grant_o, uart_write_o, uart_write_address_o,
             uart_write_data_o, uart_write_strobe_o
   );

   modport slave (
      output req_valid_i, req_data_i, req_last_i, uart_write_error_i, uart_write_done_i,
      input  req_ready_o, grant_o, uart_write_o, uart_write_address_o,
             uart_write_data_o, uart_write_strobe_o
   );
endinterface

// File: rtl/round_robin_picker.sv
// Combinational round-robin pick: one-hot grant to the first requester at or
// above ptr_i, wrapping modulo NUM_REQ.
module round_robin_picker #(
   parameter  int NUM_REQ = 4,
   localparam int PW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] grant_o
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      grant_o = '0;
      found   = 1'b0;
      idx     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = PW'((int'(ptr_i) + i) % NUM_REQ);
         if (req_i[idx] && !found) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX buffer between NUM_REQ byte streams;
// holds the grant for a frame and re-issues each write until the uart takes it.
module uart_tx_arbiter
   import uart_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int MAX_FRAME    = 64,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   uart_tx_arbiter_if.master         bus,
   output logic                      busy_o
);

   localparam int PW = $clog2(NUM_REQ);
   localparam int BW = $clog2(MAX_FRAME + 1);
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);

   uart_arb_state_t      state_q, state_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]        byte_cnt_q, byte_cnt_d;
   logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
   logic [7:0]           hold_data_q, hold_data_d;
   logic                 hold_last_q, hold_last_d;

   logic [NUM_REQ-1:0]   pick;
   logic [PW-1:0]        pick_idx;
   logic [PW-1:0]        owner_next;
   logic                 release_c;
   logic [NUM_REQ-1:0]   ready_c;
   logic                 write_c;
   logic [1:0]           addr_c;
   logic [31:0]          data_c;
   logic [3:0]           strobe_c;

   round_robin_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i   (bus.req_valid_i),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (pick[i]) pick_idx = PW'(i);
   end

   assign owner_next = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      grant_d     = grant_q;
      rr_ptr_d    = rr_ptr_q;
      byte_cnt_d  = byte_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
      release_c   = 1'b0;
      ready_c     = '0;
      write_c     = 1'b0;
      addr_c      = '0;
      data_c      = '0;
      strobe_c    = '0;

      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid_i) begin
               owner_d    = pick_idx;
               grant_d    = pick;
               byte_cnt_d = '0;
               idle_cnt_d = '0;
               state_d    = LOCKED;
            end
         end
         LOCKED: begin
            if (bus.req_valid_i[owner_q]) begin
               ready_c[owner_q] = 1'b1;
               hold_data_d      = bus.req_data_i[{owner_q, 3'b000} +: 8];
               hold_last_d      = bus.req_last_i[owner_q];
               idle_cnt_d       = '0;
               state_d          = WRITE;
            end else if (idle_cnt_q == IW'(IDLE_TIMEOUT - 1)) begin
               release_c = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + IW'(1);
            end
         end
         WRITE: begin
            write_c  = 1'b1;
            addr_c   = UART_TX_BUFFER_ADDR;
            data_c   = {24'b0, hold_data_q};
            strobe_c = UART_TX_STROBE;
            // error means the buffer was full: stay here and write again
            if (bus.uart_write_done_i && !bus.uart_write_error_i) begin
               byte_cnt_d = byte_cnt_q + BW'(1);
               if (hold_last_q || byte_cnt_d == BW'(MAX_FRAME)) release_c = 1'b1;
               else                                             state_d   = LOCKED;
            end
         end
         default: state_d = IDLE;
      endcase

      if (release_c) begin
         rr_ptr_d = owner_next;
         grant_d  = '0;
         state_d  = IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         grant_q     <= '0;
         rr_ptr_q    <= '0;
         byte_cnt_q  <= '0;
         idle_cnt_q  <= '0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         grant_q     <= grant_d;
         rr_ptr_q    <= rr_ptr_d;
         byte_cnt_q  <= byte_cnt_d;
         idle_cnt_q  <= idle_cnt_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
      end
   end

   assign bus.req_ready_o          = ready_c;
   assign bus.grant_o              = grant_q;
   assign bus.uart_write_o         = write_c;
   assign bus.uart_write_address_o = addr_c;
   assign bus.uart_write_data_o    = data_c;
   assign bus.uart_write_strobe_o  = strobe_c;
   assign busy_o                   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized frames and
// uart errors, scored against a frame-level round-robin model.
module tb_uart_tx_arbiter;
   import uart_arbiter_pkg::*;

   localparam int N     = 4;
   localparam int MAXF  = 64;
   localparam int IDLET = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } rb_t;

   logic clk, rst, busy;
   uart_tx_arbiter_if #(.NUM_REQ(N)) bus();

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_FRAME(MAXF), .IDLE_TIMEOUT(IDLET)) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus    (bus),
      .busy_o (busy)
   );

   // uart model: a write completes in its own cycle; error is bench-driven
   assign bus.uart_write_done_i = bus.uart_write_o;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rb_t        rq[N][$];
   logic [7:0] exp_d[$];
   int         exp_o[$];
   int         idle_at[$], wr_cyc[$], att_q[$];
   int         gf[N], gl[N];
   int         nvec, nerr, iter, n_wr, n_err, attempts;
   int         err_target, err_len, err_used, exp_frames, exp_bytes, exp_ptr;
   bit         err_rand, force_err, rst_next;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_frame(input int k, input int len, input int base, input bit with_last);
      rb_t e;
      for (int i = 0; i < len; i++) begin
         e.data = 8'(base + i);
         e.last = with_last && (i == len - 1);
         rq[k].push_back(e);
      end
   endtask

   // Frame-level reference: round-robin over requesters holding data, each
   // grant drains one frame (last, MAX_FRAME bytes, or the stream runs dry).
   task automatic model();
      rb_t mq[N][$];
      rb_t e;
      int  ptr, k, cnt;
      exp_d.delete(); exp_o.delete();
      exp_frames = 0; exp_bytes = 0; ptr = 0;
      for (int j = 0; j < N; j++) mq[j] = rq[j];
      forever begin
         k = -1;
         for (int i = 0; i < N; i++)
            if (k < 0 && mq[(ptr + i) % N].size() > 0) k = (ptr + i) % N;
         if (k < 0) break;
         cnt = 0;
         do begin
            e = mq[k].pop_front();
            exp_d.push_back(e.data);
            exp_o.push_back(k);
            cnt++;
         end while (!e.last && cnt < MAXF && mq[k].size() > 0);
         exp_frames++;
         exp_bytes += cnt;
         ptr = (k + 1) % N;
      end
      exp_ptr = ptr;
   endtask

   task automatic clear_log();
      idle_at.delete(); wr_cyc.delete(); att_q.delete();
      for (int k = 0; k < N; k++) begin gf[k] = -1; gl[k] = -1; end
      iter = 0; n_wr = 0; n_err = 0; attempts = 0;
      err_target = -1; err_len = 0; err_used = 0;
      err_rand = 0; force_err = 0;
   endtask

   function automatic bit all_empty();
      for (int k = 0; k < N; k++) if (rq[k].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock: drive at negedge, sample 2 units later, score the handshakes.
   task automatic step();
      logic [N-1:0] rdy, gnt, vld;
      logic         wr, err;
      @(negedge clk);
      rst = rst_next;
      for (int k = 0; k < N; k++) begin
         if (rq[k].size() > 0) begin
            bus.req_valid_i[k]        = 1'b1;
            bus.req_data_i[k*8 +: 8]  = rq[k][0].data;
            bus.req_last_i[k]         = rq[k][0].last;
         end else begin
            bus.req_valid_i[k]        = 1'b0;
            bus.req_data_i[k*8 +: 8]  = 8'($urandom);
            bus.req_last_i[k]         = 1'($urandom);
         end
      end
      err = 1'b0;
      if (bus.uart_write_o) begin
         attempts++;
         if (force_err)     err = 1'b1;
         else if (err_rand) err = ($urandom_range(0, 3) == 0);
         else if (n_wr == err_target && err_used < err_len) begin
            err = 1'b1;
            err_used++;
         end
         if (err) n_err++;
      end
      bus.uart_write_error_i = err;
      #2;
      rdy = bus.req_ready_o; gnt = bus.grant_o; vld = bus.req_valid_i; wr = bus.uart_write_o;
      if (!rst) begin
         chk("rdy_1hot", $countones(rdy) <= 1, 1);
         chk("rdy_own",  rdy & ~gnt, 0);
         chk("rdy_vld",  rdy & ~vld, 0);
         chk("rdy_wr",   wr ? rdy : '0, 0);
         chk("strobe",   bus.uart_write_strobe_o, wr ? 4'b0001 : 4'b0000);
         chk("addr",     bus.uart_write_address_o, wr ? UART_TX_BUFFER_ADDR : 2'b00);
         chk("data_hi",  bus.uart_write_data_o[31:8], 0);
         chk("gnt_1hot", $countones(gnt) <= 1, 1);
         chk("gnt_busy", |gnt, busy);
      end
      if (!busy) idle_at.push_back(n_wr);
      for (int k = 0; k < N; k++) begin
         if (gnt[k]) begin
            if (gf[k] < 0) gf[k] = iter;
            gl[k] = iter;
         end
         if (rdy[k] && vld[k]) void'(rq[k].pop_front());
      end
      if (wr && !err && !rst) begin
         n_wr++;
         wr_cyc.push_back(iter);
         att_q.push_back(attempts);
         attempts = 0;
         if (exp_d.size() == 0) chk("wr_extra", 1, 0);
         else begin
            chk("wr_data",  bus.uart_write_data_o[7:0], exp_d.pop_front());
            chk("wr_owner", gnt, 32'(1) << exp_o.pop_front());
         end
      end
      iter++;
   endtask

   task automatic reset_dut();
      for (int k = 0; k < N; k++) rq[k].delete();
      rst_next = 1'b1;
      repeat (3) step();
      rst_next = 1'b0;
      clear_log();
   endtask

   task automatic run(input int budget);
      forever begin
         step();
         if (all_empty() && !busy) break;
         if (iter >= budget) begin
            chk("timeout", iter, 0);
            break;
         end
      end
   endtask

   task automatic end_run(input string tag, input bit chk_len);
      chk({tag, "_left"}, exp_d.size(), 0);
      chk({tag, "_ptr"}, dut.rr_ptr_q, exp_ptr);
      if (chk_len) chk({tag, "_cycles"}, iter, exp_frames + 2 * exp_bytes + n_err + 1);
   endtask

   task automatic chk_q(input string tag, input int q[$], input int exp[$]);
      chk({tag, "_n"}, q.size(), exp.size());
      for (int i = 0; i < q.size() && i < exp.size(); i++)
         chk($sformatf("%s_%0d", tag, i), q[i], exp[i]);
   endtask

   initial begin
      nvec = 0; nerr = 0;
      rst = 1'b1; rst_next = 1'b1;
      bus.req_valid_i = '0; bus.req_data_i = '0; bus.req_last_i = '0;
      bus.uart_write_error_i = 1'b0;
      clear_log();

      // reset state
      reset_dut();
      chk("rst_grant", bus.grant_o, 0);
      chk("rst_ready", bus.req_ready_o, 0);
      chk("rst_write", bus.uart_write_o, 0);
      chk("rst_data",  bus.uart_write_data_o, 0);
      chk("rst_strb",  bus.uart_write_strobe_o, 0);
      chk("rst_addr",  bus.uart_write_address_o, 0);
      chk("rst_busy",  busy, 0);
      chk("rst_ptr",   dut.rr_ptr_q, 0);

      // single 3-byte frame: writes at cycles 2/4/6
      reset_dut();
      push_frame(0, 3, 'h41, 1);
      model(); run(200);
      chk_q("t1_wcyc", wr_cyc, '{2, 4, 6});
      chk_q("t1_idle", idle_at, '{0, 3});
      chk("t1_gfirst", gf[0], 1);
      chk("t1_glast", gl[0], 6);
      end_run("t1", 1);

      // two contenders from reset
      reset_dut();
      push_frame(0, 2, 'h10, 1); push_frame(2, 2, 'h20, 1);
      model(); run(200);
      chk("t2_ptr3", dut.rr_ptr_q, 3);
      chk("t2_order", gl[0] < gf[2], 1);
      end_run("t2", 1);

      // five error cycles on the second byte
      reset_dut();
      push_frame(0, 2, 'hA0, 1); push_frame(2, 2, 'hB0, 1);
      err_target = 1; err_len = 5;
      model(); run(200);
      chk_q("t3_att", att_q, '{1, 6, 1, 1});
      chk("t3_nerr", n_err, 5);
      end_run("t3", 1);

      // 70-byte stream without last: forced release after 64
      reset_dut();
      push_frame(1, 70, 0, 0);
      model(); run(600);
      chk_q("t4_idle", idle_at, '{0, 64, 70});
      chk("t4_gfirst", gf[1], 1);
      chk("t4_cycles", iter, 159);
      end_run("t4", 0);

      // owner stalls after one byte; requester 3 waits
      reset_dut();
      push_frame(0, 1, 'h80, 0); push_frame(3, 2, 'h90, 1);
      model(); run(300);
      chk("t5_glast0", gl[0], 18);
      chk("t5_gfirst3", gf[3], 20);
      chk_q("t5_idle", idle_at, '{0, 1, 3});
      end_run("t5", 0);

      // reset while a write is pending
      reset_dut();
      push_frame(0, 1, 'h5A, 1);
      model();
      step(); step();
      rst_next = 1'b1; force_err = 1'b1;
      step();
      chk("t6_wr_before", bus.uart_write_o, 1);
      rst_next = 1'b0; force_err = 1'b0;
      step();
      chk("t6_grant", bus.grant_o, 0);
      chk("t6_ready", bus.req_ready_o, 0);
      chk("t6_write", bus.uart_write_o, 0);
      chk("t6_data",  bus.uart_write_data_o, 0);
      chk("t6_strb",  bus.uart_write_strobe_o, 0);
      chk("t6_busy",  busy, 0);
      repeat (8) step();
      chk("t6_nwr", n_wr, 0);

      // randomized frames with random uart errors
      for (int r = 0; r < 20; r++) begin
         reset_dut();
         for (int k = 0; k < N; k++) begin
            int nf;
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++)
               push_frame(k, $urandom_range(1, 6), $urandom_range(0, 255), 1);
         end
         err_rand = 1'b1;
         model(); run(3000);
         end_run($sformatf("rnd%0d", r), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
